// File: rtl/entrada_io.sv
// IN-instruction input port: stalls the PC, waits for a debounced button press, latches switches.
// Optional: define ENTRADA_SINAL_EN to sign-extend the captured switch value instead of zero-extend.
module entrada_io #(
  parameter int unsigned LARGURA_CHAVES = 16,
  parameter int unsigned DEB_CICLOS     = 50000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      pedido_in,
  input  logic [LARGURA_CHAVES-1:0] chaves,
  input  logic                      botao,
  output logic [31:0]               dados_io,
  output logic                      pronto,
  output logic                      parado,
  output logic                      aguardando
);

  localparam int unsigned CntW = $clog2(DEB_CICLOS);
  localparam logic [CntW-1:0] CntMax = CntW'(DEB_CICLOS - 1);

  typedef enum logic [1:0] {
    StOcioso,
    StSolta,
    StEspera,
    StCaptura
  } estado_e;

  estado_e estado_q, estado_d;

  logic                      botao_s1_q, botao_s2_q;
  logic [LARGURA_CHAVES-1:0] chaves_s1_q, chaves_s2_q;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic                      botao_deb_q, botao_deb_d;
  logic                      botao_ant_q;
  logic [31:0]               dados_q, dados_d;
  logic [31:0]               chaves_ext;
  logic                      subida;
  logic                      captura;

  // Two-flop synchronisers for the asynchronous board inputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      botao_s1_q  <= 1'b0;
      botao_s2_q  <= 1'b0;
      chaves_s1_q <= '0;
      chaves_s2_q <= '0;
    end else begin
      botao_s1_q  <= botao;
      botao_s2_q  <= botao_s1_q;
      chaves_s1_q <= chaves;
      chaves_s2_q <= chaves_s1_q;
    end
  end

  // Level changes are accepted only after DEB_CICLOS consecutive mismatching cycles.
  always_comb begin
    cnt_d       = cnt_q;
    botao_deb_d = botao_deb_q;
    if (botao_s2_q != botao_deb_q) begin
      if (cnt_q == CntMax) begin
        botao_deb_d = botao_s2_q;
        cnt_d       = '0;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  assign subida = botao_deb_q & ~botao_ant_q;

  if (LARGURA_CHAVES == 32) begin : g_sem_ext
    assign chaves_ext = chaves_s2_q;
  end else begin : g_ext
`ifdef ENTRADA_SINAL_EN
    assign chaves_ext = {{(32 - LARGURA_CHAVES){chaves_s2_q[LARGURA_CHAVES-1]}}, chaves_s2_q};
`else
    assign chaves_ext = {{(32 - LARGURA_CHAVES){1'b0}}, chaves_s2_q};
`endif
  end

  always_comb begin
    estado_d = estado_q;
    captura  = 1'b0;
    unique case (estado_q)
      StOcioso: begin
        if (pedido_in) begin
          estado_d = botao_deb_q ? StSolta : StEspera;
        end
      end
      // Button was already held when the request arrived: wait for release first.
      StSolta: begin
        if (!pedido_in) begin
          estado_d = StOcioso;
        end else if (!botao_deb_q) begin
          estado_d = StEspera;
        end
      end
      StEspera: begin
        if (!pedido_in) begin
          estado_d = StOcioso;
        end else if (subida) begin
          estado_d = StCaptura;
          captura  = 1'b1;
        end
      end
      StCaptura: estado_d = StOcioso;
      default:   estado_d = StOcioso;
    endcase
  end

  assign dados_d = captura ? chaves_ext : dados_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q    <= StOcioso;
      cnt_q       <= '0;
      botao_deb_q <= 1'b0;
      botao_ant_q <= 1'b0;
      dados_q     <= '0;
    end else begin
      estado_q    <= estado_d;
      cnt_q       <= cnt_d;
      botao_deb_q <= botao_deb_d;
      botao_ant_q <= botao_deb_q;
      dados_q     <= dados_d;
    end
  end

  assign dados_io   = dados_q;
  assign pronto     = (estado_q == StCaptura);
  assign parado     = pedido_in && (estado_q != StCaptura);
  assign aguardando = (estado_q == StEspera) || (estado_q == StSolta);

endmodule

// File: tb/tb_entrada_io.sv
// Self-checking bench for entrada_io: table of switch captures plus hand-written handshake corners.
module tb_entrada_io;

  localparam int unsigned LARG = 16;
  localparam int unsigned DEB  = 4;

  logic            clock;
  logic            reset;
  logic            pedido_in;
  logic [LARG-1:0] chaves;
  logic            botao;
  logic [31:0]     dados_io;
  logic            pronto;
  logic            parado;
  logic            aguardando;

  entrada_io #(
    .LARGURA_CHAVES(LARG),
    .DEB_CICLOS    (DEB)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .pedido_in (pedido_in),
    .chaves    (chaves),
    .botao     (botao),
    .dados_io  (dados_io),
    .pronto    (pronto),
    .parado    (parado),
    .aguardando(aguardando)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] sw;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[5];
  logic [31:0] sb[$];
  int          checks = 0;
  int          errors = 0;
  int          pronto_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every pronto must match the oldest pending expected word.
  always @(negedge clock) begin
    if (!reset && pronto) begin
      pronto_count++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pronto_unexpected: pronto=1 dados_io=%h, expected no capture", dados_io);
      end else begin
        check("dados_io_at_pronto", dados_io, sb.pop_front());
      end
      check("parado_at_pronto", {31'b0, parado}, 32'd0);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_pronto(input int max_cyc);
    int n;
    n = 0;
    while (!pronto && n < max_cyc) begin
      @(negedge clock);
      n++;
    end
    check("pronto_within_budget", {31'b0, pronto}, 32'd1);
  endtask

  // Set switches, let them settle through the synchroniser, then press and hold.
  task automatic do_press(input logic [15:0] sw, input logic [31:0] exp);
    chaves = sw;
    repeat (3) tick();
    sb.push_back(exp);
    botao = 1'b1;
    wait_pronto(40);
  endtask

  task automatic let_go();
    tick();
    botao = 1'b0;
    repeat (DEB + 4) tick();
  endtask

  int          pc0;
  logic [31:0] held;

  initial begin
    vecs[0] = '{16'h8000, 32'h0000_8000};
    vecs[1] = '{16'h7FFF, 32'h0000_7FFF};
    vecs[2] = '{16'h0000, 32'h0000_0000};
    vecs[3] = '{16'hFFFF, 32'h0000_FFFF};
    vecs[4] = '{16'h00A5, 32'h0000_00A5};
`ifdef ENTRADA_SINAL_EN
    vecs[0].exp = 32'hFFFF_8000;
    vecs[3].exp = 32'hFFFF_FFFF;
`endif

    // Reset state
    reset = 1'b1; pedido_in = 1'b0; botao = 1'b0; chaves = '0;
    tick(); tick();
    check("rst_dados_io", dados_io, 32'd0);
    check("rst_pronto", {31'b0, pronto}, 32'd0);
    check("rst_aguardando", {31'b0, aguardando}, 32'd0);
    check("rst_parado_low", {31'b0, parado}, 32'd0);
    pedido_in = 1'b1;
    #1;
    check("rst_parado_follows_pedido", {31'b0, parado}, 32'd1);
    pedido_in = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    // Scenario 1: exact latency. Edge k=1 is the first edge that samples botao high.
    chaves = 16'h00A5;
    pedido_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("s1_parado_wait", {31'b0, parado}, 32'd1);
      check("s1_aguardando_wait", {31'b0, aguardando}, 32'd1);
    end
    sb.push_back(32'h0000_00A5);
    botao = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("s1_pronto_k%0d", k), {31'b0, pronto}, {31'b0, (k == 7)});
      check($sformatf("s1_parado_k%0d", k), {31'b0, parado}, {31'b0, (k != 7)});
      check($sformatf("s1_aguardando_k%0d", k), {31'b0, aguardando}, {31'b0, (k < 7)});
    end
    check("s1_dados_io", dados_io, 32'h0000_00A5);
    pedido_in = 1'b0;
    let_go();

    // Scenario 2: short pulses in ESPERA never reach botao_deb
    pedido_in = 1'b1;
    tick(); tick();
    pc0 = pronto_count;
    for (int r = 0; r < 5; r++) begin
      botao = 1'b1;
      repeat (2) begin
        tick();
        check("s2_deb_low", {31'b0, dut.botao_deb_q}, 32'd0);
      end
      botao = 1'b0;
      repeat (3) begin
        tick();
        check("s2_deb_low", {31'b0, dut.botao_deb_q}, 32'd0);
      end
    end
    repeat (4) tick();
    check("s2_no_pronto", pronto_count, pc0);
    check("s2_dados_kept", dados_io, 32'h0000_00A5);
    check("s2_still_waiting", {31'b0, aguardando}, 32'd1);

    // Scenario 6: abort from ESPERA
    pedido_in = 1'b0;
    tick();
    check("s6_aguardando", {31'b0, aguardando}, 32'd0);
    check("s6_parado", {31'b0, parado}, 32'd0);
    repeat (5) tick();
    check("s6_no_pronto", pronto_count, pc0);
    check("s6_dados_kept", dados_io, 32'h0000_00A5);

    // Scenario 3: button already held when the request arrives
    botao = 1'b1;
    repeat (10) tick();
    check("s3_deb_high", {31'b0, dut.botao_deb_q}, 32'd1);
    pc0 = pronto_count;
    pedido_in = 1'b1;
    tick();
    check("s3_solta_waiting", {31'b0, aguardando}, 32'd1);
    repeat (10) tick();
    check("s3_no_capture_while_held", pronto_count, pc0);
    check("s3_parado_held", {31'b0, parado}, 32'd1);
    botao = 1'b0;
    repeat (8) tick();
    check("s3_espera_waiting", {31'b0, aguardando}, 32'd1);
    do_press(16'h0042, 32'h0000_0042);
    tick();
    check("s3_single_pronto", pronto_count, pc0 + 1);
    pedido_in = 1'b0;
    let_go();

    // Scenario 4: back-to-back IN with pedido_in held; each value needs its own press
    pedido_in = 1'b1;
    tick(); tick();
    pc0 = pronto_count;
    do_press(16'h1234, 32'h0000_1234);
    repeat (12) tick();
    check("s4_one_pronto_while_held", pronto_count, pc0 + 1);
    check("s4_first_value", dados_io, 32'h0000_1234);
    check("s4_solta_waiting", {31'b0, aguardando}, 32'd1);
    chaves = 16'hFFFE;
    botao = 1'b0;
    repeat (8) tick();
`ifdef ENTRADA_SINAL_EN
    do_press(16'hFFFE, 32'hFFFF_FFFE);
`else
    do_press(16'hFFFE, 32'h0000_FFFE);
`endif
    tick();
    check("s4_two_prontos", pronto_count, pc0 + 2);
    pedido_in = 1'b0;
    let_go();

    // Table-driven captures
    foreach (vecs[i]) begin
      pedido_in = 1'b1;
      tick();
      do_press(vecs[i].sw, vecs[i].exp);
      tick();
      check($sformatf("tbl%0d_dados_io", i), dados_io, vecs[i].exp);
      pedido_in = 1'b0;
      let_go();
    end

    // Scenario 5: asynchronous reset between edges while in ESPERA
    held = dados_io;
    pedido_in = 1'b1;
    tick(); tick();
    check("s5_pre_waiting", {31'b0, aguardando}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("s5_rst_dados_io", dados_io, 32'd0);
    check("s5_rst_pronto", {31'b0, pronto}, 32'd0);
    check("s5_rst_aguardando", {31'b0, aguardando}, 32'd0);
    check("s5_rst_parado", {31'b0, parado}, 32'd1);
    tick();
    reset = 1'b0;
    tick();
    check("s5_after_rst_waiting", {31'b0, aguardando}, 32'd1);
    do_press(16'h5A5A, 32'h0000_5A5A);
    tick();
    check("s5_after_rst_dados", dados_io, 32'h0000_5A5A);
    pedido_in = 1'b0;
    let_go();

    check("scoreboard_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
